dcache_data_arb_pipe: RTL and testbench

DCACHE_DATA_ARB_PIPE -- requirements
Module: dcache_data_arb_pipe

---
 rtl/dcache_data_arb_pipe_pkg.sv | 45 ++++
 rtl/dcache_data_arb_pipe_grant.sv | 58 +++++
 rtl/dcache_data_arb_pipe.sv | 162 ++++++++++++++++
 tb/tb_dcache_data_arb_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_data_arb_pipe_pkg.sv
// -----------------------------------------------------------------------------
// dcache_data_arb_pipe_pkg
// Shared definitions for the dcache data-array request arbiter:
//   - default widths for the requester payload fields
//   - the request-payload struct for the default configuration
//   - the index-width constant and helper functions used by the arbiter
// No ports (package).
// -----------------------------------------------------------------------------
package dcache_data_arb_pipe_pkg;

    localparam int DEF_N_IN   = 4;
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_MASK_W = DEF_DATA_W / 8;
    localparam int DEF_WAYS   = 4;
    localparam int DEF_IDX_W  = $clog2(DEF_N_IN);

    // One requester beat in the default configuration.
    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
        logic [DEF_MASK_W-1:0] ecc_mask;
        logic [DEF_WAYS-1:0]   way_en;
        logic                  last;
    } dcache_req_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // (ptr + k) modulo n for 0 <= ptr < n and 1 <= k <= n, without a divider.
    function automatic int rr_next(input int ptr, input int k, input int n);
        int s;
        s = ptr + k;
        if (s >= n) begin
            s = s - n;
        end else begin
            s = s;
        end
        return s;
    endfunction

endpackage

// File: rtl/dcache_data_arb_pipe_grant.sv
// -----------------------------------------------------------------------------
// dcache_arb_grant
// Purely combinational grant selection for the dcache data arbiter.
//   req_i      : per-channel request valid
//   rr_ptr_i   : last winner (round-robin starts searching just after it)
//   lock_i     : a burst is in progress, only lock_ch_i may be granted
//   lock_ch_i  : channel owning the burst lock
//   gnt_o      : one-hot grant (all zero when nothing is grantable)
//   gnt_idx_o  : index of the granted channel
//   gnt_any_o  : some channel is granted
// RR_MODE = 0 selects the lowest valid index, RR_MODE = 1 rotates priority.
// -----------------------------------------------------------------------------
module dcache_arb_grant
    import dcache_data_arb_pipe_pkg::*;
#(
    parameter int  N_IN    = DEF_N_IN,
    parameter int  RR_MODE = 0,
    localparam int IDX_W   = idx_w(N_IN)
) (
    input  logic [N_IN-1:0]  req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    input  logic             lock_i,
    input  logic [IDX_W-1:0] lock_ch_i,
    output logic [N_IN-1:0]  gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_any_o
);

    logic [IDX_W-1:0] cand_s;

    // Winner selection: lock overrides everything, otherwise fixed or rotating priority.
    always_comb begin
        gnt_any_o = 1'b0;
        gnt_idx_o = '0;
        gnt_o     = '0;
        cand_s    = '0;
        if (lock_i) begin
            // A stalled burst owner blocks every other channel.
            gnt_any_o = req_i[lock_ch_i];
            gnt_idx_o = lock_ch_i;
        end else if (RR_MODE == 0) begin
            // Scan high to low so the lowest valid index is the last one kept.
            for (int i = N_IN - 1; i >= 0; i--) begin
                gnt_any_o = gnt_any_o | req_i[i];
                gnt_idx_o = req_i[i] ? IDX_W'(i) : gnt_idx_o;
            end
        end else begin
            // Scan farthest to nearest after rr_ptr; k = N_IN revisits rr_ptr itself last.
            for (int k = N_IN; k >= 1; k--) begin
                cand_s    = IDX_W'(rr_next(int'(rr_ptr_i), k, N_IN));
                gnt_any_o = gnt_any_o | req_i[cand_s];
                gnt_idx_o = req_i[cand_s] ? cand_s : gnt_idx_o;
            end
        end
        gnt_o[gnt_idx_o] = gnt_any_o;
    end

endmodule

// File: rtl/dcache_data_arb_pipe.sv
// -----------------------------------------------------------------------------
// dcache_data_arb_pipe
// Arbitrates N_IN requester channels onto one data-array request port through
// a single output register (latency 1, one beat per cycle when out_ready=1).
// Multi-beat bursts (in_last=0) lock the arbiter onto their channel.
//   clock / reset            : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready      : per-channel handshake (ready only to the winner)
//   in_addr/write/wdata/eccMask/way_en/last : packed per-channel payload
//   out_valid / out_ready    : registered request handshake to the data array
//   out_addr/write/wdata/eccMask/way_en     : registered winner payload
//   out_chosen               : index of the channel that produced out_*
// -----------------------------------------------------------------------------
module dcache_data_arb_pipe
    import dcache_data_arb_pipe_pkg::*;
#(
    parameter int  N_IN    = DEF_N_IN,
    parameter int  ADDR_W  = DEF_ADDR_W,
    parameter int  DATA_W  = DEF_DATA_W,
    parameter int  MASK_W  = DATA_W / 8,
    parameter int  WAYS    = DEF_WAYS,
    parameter int  RR_MODE = 0,
    localparam int IDX_W   = idx_w(N_IN)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_IN-1:0]      in_valid,
    output logic [N_IN-1:0]      in_ready,
    input  logic [N_IN*ADDR_W-1:0] in_addr,
    input  logic [N_IN-1:0]      in_write,
    input  logic [N_IN*DATA_W-1:0] in_wdata,
    input  logic [N_IN*MASK_W-1:0] in_eccMask,
    input  logic [N_IN*WAYS-1:0] in_way_en,
    input  logic [N_IN-1:0]      in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 out_write,
    output logic [DATA_W-1:0]    out_wdata,
    output logic [MASK_W-1:0]    out_eccMask,
    output logic [WAYS-1:0]      out_way_en,
    output logic [IDX_W-1:0]     out_chosen
);

    // Output register and arbitration state.
    logic              out_valid_q,  out_valid_d;
    logic [ADDR_W-1:0] out_addr_q,   out_addr_d;
    logic              out_write_q,  out_write_d;
    logic [DATA_W-1:0] out_wdata_q,  out_wdata_d;
    logic [MASK_W-1:0] out_mask_q,   out_mask_d;
    logic [WAYS-1:0]   out_way_q,    out_way_d;
    logic [IDX_W-1:0]  out_chosen_q, out_chosen_d;
    logic [IDX_W-1:0]  rr_ptr_q,     rr_ptr_d;
    logic              lock_q,       lock_d;
    logic [IDX_W-1:0]  lock_ch_q,    lock_ch_d;

    logic [N_IN-1:0]   gnt_s;
    logic [IDX_W-1:0]  gnt_idx_s;
    logic              gnt_any_s;
    logic              load_en_s;
    logic              accept_s;

    logic [ADDR_W-1:0] sel_addr_s;
    logic              sel_write_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic [MASK_W-1:0] sel_mask_s;
    logic [WAYS-1:0]   sel_way_s;
    logic              sel_last_s;

    dcache_arb_grant #(
        .N_IN    (N_IN),
        .RR_MODE (RR_MODE)
    ) u_grant (
        .req_i     (in_valid),
        .rr_ptr_i  (rr_ptr_q),
        .lock_i    (lock_q),
        .lock_ch_i (lock_ch_q),
        .gnt_o     (gnt_s),
        .gnt_idx_o (gnt_idx_s),
        .gnt_any_o (gnt_any_s)
    );

    // The register can take a new beat when empty or when its content leaves this cycle.
    assign load_en_s = ~out_valid_q | out_ready;
    // reset gates the handshake so nothing is accepted while reset is held low.
    assign accept_s  = gnt_any_s & load_en_s & reset;
    assign in_ready  = gnt_s & {N_IN{load_en_s & reset}};

    // Winner payload mux.
    assign sel_addr_s  = in_addr[gnt_idx_s*ADDR_W +: ADDR_W];
    assign sel_write_s = in_write[gnt_idx_s];
    assign sel_wdata_s = in_wdata[gnt_idx_s*DATA_W +: DATA_W];
    assign sel_mask_s  = in_eccMask[gnt_idx_s*MASK_W +: MASK_W];
    assign sel_way_s   = in_way_en[gnt_idx_s*WAYS +: WAYS];
    assign sel_last_s  = in_last[gnt_idx_s];

    // Next-state: load on accept, drain on an empty cycle, otherwise hold under backpressure.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_addr_d   = out_addr_q;
        out_write_d  = out_write_q;
        out_wdata_d  = out_wdata_q;
        out_mask_d   = out_mask_q;
        out_way_d    = out_way_q;
        out_chosen_d = out_chosen_q;
        rr_ptr_d     = rr_ptr_q;
        lock_d       = lock_q;
        lock_ch_d    = lock_ch_q;
        if (accept_s) begin
            out_valid_d  = 1'b1;
            out_addr_d   = sel_addr_s;
            out_write_d  = sel_write_s;
            out_wdata_d  = sel_wdata_s;
            out_mask_d   = sel_mask_s;
            out_way_d    = sel_way_s;
            out_chosen_d = gnt_idx_s;
            rr_ptr_d     = gnt_idx_s;
            // A non-final beat (re)arms the lock; the final beat releases it.
            lock_d       = ~sel_last_s;
            lock_ch_d    = gnt_idx_s;
        end else if (load_en_s) begin
            out_valid_d  = 1'b0;
        end else begin
            out_valid_d  = out_valid_q;
        end
    end

    // State registers; reset drops any burst lock and points rr_ptr so channel 0 wins first.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            out_write_q  <= 1'b0;
            out_wdata_q  <= '0;
            out_mask_q   <= '0;
            out_way_q    <= '0;
            out_chosen_q <= '0;
            rr_ptr_q     <= IDX_W'(N_IN - 1);
            lock_q       <= 1'b0;
            lock_ch_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            out_write_q  <= out_write_d;
            out_wdata_q  <= out_wdata_d;
            out_mask_q   <= out_mask_d;
            out_way_q    <= out_way_d;
            out_chosen_q <= out_chosen_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            lock_ch_q    <= lock_ch_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_addr    = out_addr_q;
    assign out_write   = out_write_q;
    assign out_wdata   = out_wdata_q;
    assign out_eccMask = out_mask_q;
    assign out_way_en  = out_way_q;
    assign out_chosen  = out_chosen_q;

endmodule

// File: tb/tb_dcache_data_arb_pipe.sv
// -----------------------------------------------------------------------------
// tb_dcache_data_arb_pipe
// Drives a fixed-priority and a round-robin instance with the same stimulus and
// compares both against a behavioural model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_dcache_data_arb_pipe;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 64;
    localparam int MW = 8;
    localparam int WY = 4;
    localparam int IW = 2;
    localparam int OW = 1 + IW + 1 + AW + DW + MW + WY;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]    in_valid, in_write, in_last;
    logic [N*AW-1:0] in_addr;
    logic [N*DW-1:0] in_wdata;
    logic [N*MW-1:0] in_mask;
    logic [N*WY-1:0] in_way;
    logic            out_ready;

    logic [N-1:0]  rdy_fx, rdy_rr;
    logic          ov_fx, ov_rr, ow_fx, ow_rr;
    logic [AW-1:0] oa_fx, oa_rr;
    logic [DW-1:0] od_fx, od_rr;
    logic [MW-1:0] ok_fx, ok_rr;
    logic [WY-1:0] oy_fx, oy_rr;
    logic [IW-1:0] ch_fx, ch_rr;

    dcache_data_arb_pipe #(.N_IN(N), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .WAYS(WY), .RR_MODE(0)) dut_fx (
        .clock(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(rdy_fx), .in_addr(in_addr),
        .in_write(in_write), .in_wdata(in_wdata), .in_eccMask(in_mask), .in_way_en(in_way),
        .in_last(in_last), .out_valid(ov_fx), .out_ready(out_ready), .out_addr(oa_fx),
        .out_write(ow_fx), .out_wdata(od_fx), .out_eccMask(ok_fx), .out_way_en(oy_fx),
        .out_chosen(ch_fx));

    dcache_data_arb_pipe #(.N_IN(N), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .WAYS(WY), .RR_MODE(1)) dut_rr (
        .clock(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(rdy_rr), .in_addr(in_addr),
        .in_write(in_write), .in_wdata(in_wdata), .in_eccMask(in_mask), .in_way_en(in_way),
        .in_last(in_last), .out_valid(ov_rr), .out_ready(out_ready), .out_addr(oa_rr),
        .out_write(ow_rr), .out_wdata(od_rr), .out_eccMask(ok_rr), .out_way_en(oy_rr),
        .out_chosen(ch_rr));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model, index 0 = fixed priority, 1 = round-robin.
    bit            m_lk  [2];
    int            m_lkc [2];
    int            m_ptr [2];
    logic          m_ov  [2];
    logic [IW-1:0] m_ch  [2];
    logic          m_wr  [2];
    logic [AW-1:0] m_a   [2];
    logic [DW-1:0] m_d   [2];
    logic [MW-1:0] m_k   [2];
    logic [WY-1:0] m_w   [2];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_lk[m] = 1'b0; m_lkc[m] = 0; m_ptr[m] = N - 1;
            m_ov[m] = 1'b0; m_ch[m] = '0; m_wr[m] = 1'b0;
            m_a[m] = '0; m_d[m] = '0; m_k[m] = '0; m_w[m] = '0;
        end
    endtask

    // Channel the rules say should win now, or -1.
    function automatic int pick(input int m);
        int c;
        if (m_lk[m]) return in_valid[m_lkc[m]] ? m_lkc[m] : -1;
        for (int k = 1; k <= N; k++) begin
            c = (m == 0) ? (k - 1) : ((m_ptr[m] + k) % N);
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready(input int m);
        logic [N-1:0] one;
        int w;
        one = 1;
        w = pick(m);
        if (rst_n && (!m_ov[m] || out_ready) && w >= 0) return one << w;
        return '0;
    endfunction

    function automatic logic [OW-1:0] exp_out(input int m);
        return {m_ov[m], m_ch[m], m_wr[m], m_a[m], m_d[m], m_k[m], m_w[m]};
    endfunction

    function automatic logic [OW-1:0] dut_out(input int m);
        if (m == 0) return {ov_fx, ch_fx, ow_fx, oa_fx, od_fx, ok_fx, oy_fx};
        return {ov_rr, ch_rr, ow_rr, oa_rr, od_rr, ok_rr, oy_rr};
    endfunction

    task automatic model_clock();
        int w;
        logic le;
        logic [N-1:0] r;
        for (int m = 0; m < 2; m++) begin
            le = !m_ov[m] || out_ready;
            r  = exp_ready(m);
            w  = pick(m);
            if (!rst_n) begin
                m_ov[m] = 1'b0;
            end else if (r != '0) begin
                m_ov[m] = 1'b1; m_ch[m] = IW'(w); m_wr[m] = in_write[w];
                m_a[m] = in_addr[w*AW +: AW]; m_d[m] = in_wdata[w*DW +: DW];
                m_k[m] = in_mask[w*MW +: MW]; m_w[m] = in_way[w*WY +: WY];
                m_ptr[m] = w; m_lk[m] = !in_last[w]; m_lkc[m] = w;
            end else if (le) begin
                m_ov[m] = 1'b0;
            end
        end
    endtask

    // Check the current cycle against the model, advance the model, move to the next negedge.
    task automatic tick();
        #1;
        chk("fx_in_ready", rdy_fx, exp_ready(0));
        chk("rr_in_ready", rdy_rr, exp_ready(1));
        chk("fx_out", dut_out(0), exp_out(0));
        chk("rr_out", dut_out(1), exp_out(1));
        model_clock();
        @(negedge clk);
    endtask

    task automatic rnd_payload();
        for (int c = 0; c < N; c++) begin
            in_addr[c*AW +: AW]  = AW'($urandom);
            in_wdata[c*DW +: DW] = {$urandom, $urandom};
            in_mask[c*MW +: MW]  = MW'($urandom);
            in_way[c*WY +: WY]   = WY'($urandom);
            in_write[c]          = 1'($urandom);
        end
    endtask

    task automatic reset_pulse();
        in_valid = '0;
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    int seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        in_valid = '0; in_write = '0; in_last = '1; in_addr = '0;
        in_wdata = '0; in_mask = '0; in_way = '0; out_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        tick();
        chk("reset_out_valid", ov_fx, 1'b0);
        chk("reset_chosen", ch_rr, 2'd0);
        rst_n = 1'b1;

        // Fixed priority picks the lowest valid index.
        rnd_payload();
        in_valid = 4'b1010; in_last = 4'b1111; out_ready = 1'b1;
        #1 chk("fixed_in_ready", rdy_fx, 4'b0010);
        tick();
        chk("fixed_out_valid", ov_fx, 1'b1);
        chk("fixed_chosen", ch_fx, 2'd1);

        // Round-robin rotation from a fresh reset.
        reset_pulse();
        in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rnd_payload();
            tick();
            chk("rr_sequence", ch_rr, seq[i]);
        end

        // Burst lock on channel 2 with channel 0 competing.
        reset_pulse();
        out_ready = 1'b1;
        rnd_payload(); in_valid = 4'b0100; in_last = 4'b1011;
        tick(); chk("lock_beat1", ch_fx, 2'd2);
        rnd_payload(); in_valid = 4'b0101;
        tick(); chk("lock_beat2", ch_fx, 2'd2);
        in_valid = 4'b0001;
        #1 chk("lock_stall_ready", rdy_fx, 4'b0000);
        tick(); chk("lock_stall_valid", ov_fx, 1'b0);
        rnd_payload(); in_valid = 4'b0101;
        tick(); chk("lock_beat3", ch_fx, 2'd2);
        rnd_payload(); in_last = 4'b1111;
        tick(); chk("lock_beat4", ch_fx, 2'd2);
        rnd_payload();
        tick(); chk("lock_release", ch_fx, 2'd0);

        // Backpressure holds the output register.
        reset_pulse();
        out_ready = 1'b1; in_valid = 4'b0010; in_last = 4'b1111;
        rnd_payload(); in_addr[AW +: AW] = 12'h123;
        tick(); chk("bp_load_addr", oa_fx, 12'h123);
        out_ready = 1'b0; in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            rnd_payload();
            #1 chk("bp_fx_ready", rdy_fx, 4'b0000);
            chk("bp_rr_ready", rdy_rr, 4'b0000);
            tick();
            chk("bp_fx_addr", oa_fx, 12'h123);
            chk("bp_rr_addr", oa_rr, 12'h123);
        end
        out_ready = 1'b1; in_valid = 4'b0000;
        tick();

        // Reset in the middle of a locked burst.
        reset_pulse();
        out_ready = 1'b1; in_valid = 4'b0100; in_last = 4'b1011;
        rnd_payload(); tick();
        rnd_payload(); tick();
        rst_n = 1'b0;
        model_reset();
        #1 chk("mid_reset_fx_valid", ov_fx, 1'b0);
        chk("mid_reset_rr_valid", ov_rr, 1'b0);
        chk("mid_reset_ready", rdy_fx, 4'b0000);
        tick();
        rst_n = 1'b1;
        in_valid = 4'b0101; in_last = 4'b1111;
        rnd_payload();
        #1 chk("post_reset_fx_ready", rdy_fx, 4'b0001);
        chk("post_reset_rr_ready", rdy_rr, 4'b0001);
        tick();
        chk("post_reset_fx_chosen", ch_fx, 2'd0);
        chk("post_reset_rr_chosen", ch_rr, 2'd0);

        // Randomized traffic with bursts, stalls and occasional resets.
        for (int i = 0; i < 400; i++) begin
            in_valid = N'($urandom);
            for (int c = 0; c < N; c++) in_last[c] = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rnd_payload();
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                model_reset();
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
